// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg -- decode/execute pipeline register
//
// Captures the decoded instruction, its PC, both operands and the
// destination-register controls every cycle and presents them to the
// execute stage one cycle later. The pipeline control block can freeze the
// stage (hold_flag_i) or turn it into a bubble (jump_en_i). A bubble is the
// canonical NOP (addi x0,x0,0), so the execute stage writes nothing.
//
// Optional feature (macro ID_EX_FWD_EN):
//   When defined, a LOAD replaces an operand that carries a register value
//   with the execute stage's same-cycle write-back data if the indices match.
//   When undefined, the forwarding ports are present but ignored.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   inst_i, inst_addr_i     instruction and its PC from decode
//   op1_i, op2_i            operands from decode
//   rd_addr_i, rd_wen_i     destination register controls from decode
//   rs1_addr_i, rs2_addr_i  source indices (forwarding only)
//   op1_is_rs1_i            op1_i carries the rs1 value
//   op2_is_rs2_i            op2_i carries the rs2 value
//   hold_flag_i             freeze stage contents
//   jump_en_i               flush stage to a bubble (wins over hold)
//   ex_rd_addr_i/data/wen   execute-stage write-back (forwarding source)
//   inst_o .. rd_wen_o      registered copies presented to execute
//   valid_o                 stage holds a real instruction
//   bubble_cnt_o            saturating count of bubble cycles since reset
// ---------------------------------------------------------------------------
module id_ex_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] NOP_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        op1_is_rs1_i,
    input  logic        op2_is_rs2_i,
    input  logic        hold_flag_i,
    input  logic        jump_en_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic        ex_rd_wen_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        valid_o,
    output logic [31:0] bubble_cnt_o
);

    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [4:0]  r_rd_addr;
    logic        r_rd_wen;
    logic        r_valid;
    logic [31:0] r_bubble_cnt;

    logic [31:0] w_op1_next;
    logic [31:0] w_op2_next;
    logic        w_bubble_edge;

`ifdef ID_EX_FWD_EN
    logic w_fwd_op1;
    logic w_fwd_op2;

    // Forward only a real write to a non-zero register that the operand
    // actually reads; x0 is hard-wired to zero and must never be bypassed.
    always_comb begin
        w_fwd_op1 = op1_is_rs1_i && ex_rd_wen_i && (ex_rd_addr_i != 5'd0)
                    && (ex_rd_addr_i == rs1_addr_i);
        w_fwd_op2 = op2_is_rs2_i && ex_rd_wen_i && (ex_rd_addr_i != 5'd0)
                    && (ex_rd_addr_i == rs2_addr_i);
        w_op1_next = w_fwd_op1 ? ex_rd_data_i : op1_i;
        w_op2_next = w_fwd_op2 ? ex_rd_data_i : op2_i;
    end
`else
    // Forwarding inputs exist on the port list but carry no function here.
    logic w_unused_fwd;

    always_comb begin
        w_op1_next   = op1_i;
        w_op2_next   = op2_i;
        w_unused_fwd = ^{rs1_addr_i, rs2_addr_i, op1_is_rs1_i, op2_is_rs2_i,
                         ex_rd_addr_i, ex_rd_data_i, ex_rd_wen_i};
    end
`endif

    // Stage contents: flush beats hold, hold beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst      <= NOP_INST;
            r_inst_addr <= NOP_ADDR;
            r_op1       <= 32'd0;
            r_op2       <= 32'd0;
            r_rd_addr   <= 5'd0;
            r_rd_wen    <= 1'b0;
            r_valid     <= 1'b0;
        end else if (jump_en_i) begin
            r_inst      <= NOP_INST;
            r_inst_addr <= NOP_ADDR;
            r_op1       <= 32'd0;
            r_op2       <= 32'd0;
            r_rd_addr   <= 5'd0;
            r_rd_wen    <= 1'b0;
            r_valid     <= 1'b0;
        end else if (!hold_flag_i) begin
            r_inst      <= inst_i;
            r_inst_addr <= inst_addr_i;
            r_op1       <= w_op1_next;
            r_op2       <= w_op2_next;
            r_rd_addr   <= rd_addr_i;
            r_rd_wen    <= rd_wen_i;
            r_valid     <= 1'b1;
        end
    end

    // An edge yields a bubble when it flushes, or when it holds a stage that
    // is already a bubble.
    assign w_bubble_edge = jump_en_i || (hold_flag_i && !r_valid);

    // Saturating bubble counter; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 32'd0;
        end else if (w_bubble_edge && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign op1_o        = r_op1;
    assign op2_o        = r_op2;
    assign rd_addr_o    = r_rd_addr;
    assign rd_wen_o     = r_rd_wen;
    assign valid_o      = r_valid;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures the decoded instruction, its PC, operands, and destination-register controls from decode every cycle, and presents them to the execute stage.
- Obeys the hold and jump signals from the pipeline control block: hold freezes the stage; a jump or flush turns it into a bubble.
- Optionally forwards the execute stage's same-cycle write-back result into the captured operands.

Parameters:
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on inst_o during reset and bubbles.
- NOP_ADDR, 32'h0000_0000, PC value driven on inst_addr_o during reset and bubbles.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_i  in  32  instruction from decode.
- inst_addr_i  in  32  PC of inst_i.
- op1_i  in  32  operand 1 (rs1 value, PC-relative immediate, or U-immediate).
- op2_i  in  32  operand 2 (rs2 value or immediate).
- rd_addr_i  in  5  destination register.
- rd_wen_i  in  1  destination write enable.
- rs1_addr_i  in  5  source register 1 index (forwarding only).
- rs2_addr_i  in  5  source register 2 index (forwarding only).
- op1_is_rs1_i  in  1  op1_i carries the rs1 value.
- op2_is_rs2_i  in  1  op2_i carries the rs2 value.
- hold_flag_i  in  1  from ctrl: freeze stage contents.
- jump_en_i  in  1  from ctrl: flush stage (taken branch or jump).
- ex_rd_addr_i  in  5  execute-stage write-back address.
- ex_rd_data_i  in  32  execute-stage write-back data.
- ex_rd_wen_i  in  1  execute-stage write-back enable.
- inst_o  out  32  to ex.
- inst_addr_o  out  32  to ex.
- op1_o  out  32  to ex.
- op2_o  out  32  to ex.
- rd_addr_o  out  5  to ex.
- rd_wen_o  out  1  to ex.
- valid_o  out  1  stage holds a real (non-bubble) instruction.
- bubble_cnt_o  out  32  count of bubble cycles since reset.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values (rst_n=0), applied immediately, independent of clk:
  - inst_o=NOP_INST, inst_addr_o=NOP_ADDR.
  - op1_o=0, op2_o=0, rd_addr_o=0, rd_wen_o=0.
  - valid_o=0, bubble_cnt_o=0.
- All outputs are registered. Latency is 1 cycle from decode inputs to outputs.
- Each rising edge takes exactly one action, in this priority order:
  1. FLUSH when jump_en_i=1: load the bubble. inst_o=NOP_INST, inst_addr_o=NOP_ADDR, op1_o=0, op2_o=0, rd_addr_o=0, rd_wen_o=0, valid_o=0.
  2. HOLD when hold_flag_i=1 and jump_en_i=0: all outputs keep their values. No forwarding update is applied.
  3. LOAD otherwise: capture all decode inputs and set valid_o=1.
- Simultaneous jump_en_i and hold_flag_i: FLUSH wins.
- A bubble re-enters the pipeline as addi x0,x0,0, so the execute stage writes nothing.
- Bubble counter:
  - Increments by 1 on each edge where the registered result is a bubble: FLUSH, or HOLD while valid_o=0.
  - Saturates at 32'hFFFF_FFFF; it does not wrap.
  - Not reset by flush; cleared only by rst_n.
- Reset asserted mid-operation forces the reset values at once. The first edge after release behaves as LOAD, unless hold or jump is asserted.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: on LOAD only, forwarding is applied to each operand independently.
  - Operand 1: if op1_is_rs1_i=1, ex_rd_wen_i=1, ex_rd_addr_i!=0 and ex_rd_addr_i==rs1_addr_i, then op1_o captures ex_rd_data_i instead of op1_i.
  - Operand 2: if op2_is_rs2_i=1, ex_rd_wen_i=1, ex_rd_addr_i!=0 and ex_rd_addr_i==rs2_addr_i, then op2_o captures ex_rd_data_i instead of op2_i.
- Not defined: rs1_addr_i, rs2_addr_i, op1_is_rs1_i, op2_is_rs2_i and ex_rd_* remain ports but are ignored. The operands are always op1_i and op2_i.

Test Plan:
- Reset: hold rst_n=0 mid-cycle -> outputs go to reset values immediately: inst_o=32'h0000_0013, valid_o=0, bubble_cnt_o=0.
- LOAD: inst_i=32'h00500093, op1_i=0, op2_i=5, rd_addr_i=1, rd_wen_i=1 -> one edge later inst_o matches, op2_o=5, rd_addr_o=1, valid_o=1.
- HOLD: load inst A, then hold_flag_i=1 for 3 cycles while inputs change -> outputs stay at A for 3 edges, bubble_cnt_o unchanged.
- FLUSH priority: jump_en_i=1 and hold_flag_i=1 together, inputs=inst B -> inst_o=32'h0000_0013, rd_wen_o=0, valid_o=0, bubble_cnt_o increments by 1.
- Forwarding (ID_EX_FWD_EN defined): rs1_addr_i=3, op1_is_rs1_i=1, op1_i=7, ex_rd_addr_i=3, ex_rd_wen_i=1, ex_rd_data_i=32'hDEAD_BEEF -> op1_o=32'hDEAD_BEEF.
  - Same stimulus with ex_rd_addr_i=0 -> op1_o=7.
  - Macro undefined -> op1_o=7.
- Saturation: force the bubble count to 32'hFFFF_FFFE, then apply 3 flush edges -> bubble_cnt_o ends at 32'hFFFF_FFFF.
